// File: rtl/ex_pkg.sv
// Shared encodings and payload types for the execute stage.
package ex_pkg;

    localparam int unsigned W         = 16;
    localparam int unsigned W1        = W + 1;
    localparam int unsigned MUL_ITERS = 16;
    localparam int unsigned CNT_W     = $clog2(MUL_ITERS);
    localparam int unsigned SH_W      = $clog2(W);
    localparam int unsigned OP_W      = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
    localparam logic [OP_W-1:0] OP_AND   = 4'd2;
    localparam logic [OP_W-1:0] OP_OR    = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
    localparam logic [OP_W-1:0] OP_NOT   = 4'd5;
    localparam logic [OP_W-1:0] OP_SLL   = 4'd6;
    localparam logic [OP_W-1:0] OP_SRL   = 4'd7;
    localparam logic [OP_W-1:0] OP_SRA   = 4'd8;
    localparam logic [OP_W-1:0] OP_MUL   = 4'd9;
    localparam logic [OP_W-1:0] OP_MULH  = 4'd10;
    localparam logic [OP_W-1:0] OP_SLT   = 4'd11;
    localparam logic [OP_W-1:0] OP_PASSB = 4'd12;
    localparam logic [OP_W-1:0] OP_NOP   = 4'd13;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MBUSY = 2'd1;
    localparam logic [1:0] MDONE = 2'd2;

    // Memory/regfile control carried alongside each op
    typedef struct packed {
        logic         readMem;
        logic         writeMem;
        logic [W-1:0] dataIn;
        logic [1:0]   quarter;
        logic         write;
    } ctl_t;

    typedef struct packed {
        logic [W-1:0] result;
        logic         zero;
        logic         neg;
        logic         carry;
        logic         ovf;
    } alu_out_t;

    function automatic logic isMulOp(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/ex_mul16.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, LSB first.
module ex_mul16
    import ex_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           kill,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] prod
);

    localparam int unsigned IW = $clog2(MUL_ITERS) + 1;

    logic [W-1:0]  mcand;
    logic [IW-1:0] iter;
    logic [W:0]    partial;

    // Upper half plus multiplicand when the current multiplier bit (prod[0]) is set
    always_comb begin
        partial = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            prod  <= '0;
            iter  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                busy <= 1'b0;
            end else if (start) begin
                mcand <= a;
                prod  <= {W'(0), b};
                iter  <= IW'(MUL_ITERS);
                busy  <= 1'b1;
            end else if (busy) begin
                prod <= {partial, prod[W-1:1]};
                iter <= iter - IW'(1);
                if (iter == IW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an FSM wrapping the iterative multiplier.
module ex_stage
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [W-1:0]    readData0,
    input  logic [W-1:0]    readData1,
    input  logic [OP_W-1:0] ALUOp,
    input  logic            ReadMem,
    input  logic            WriteMem,
    input  logic [W-1:0]    DataIn,
    input  logic [1:0]      quarter,
    input  logic            write,
    input  logic            flush,
    output logic            stall,
    output logic            out_valid,
    output logic [W-1:0]    result,
    output logic            zero,
    output logic            neg,
    output logic            carry,
    output logic            ovf,
    output logic            o_ReadMem,
    output logic            o_WriteMem,
    output logic [W-1:0]    o_DataIn,
    output logic [1:0]      o_quarter,
    output logic            o_write
);

    logic [1:0]       state, stateN;
    logic [CNT_W-1:0] count, countN;
    logic             stallN, outValidN;
    alu_out_t         aluOut, outQ, outN;
    ctl_t             inCtl, ctlQ, ctlN, mulCtl, mulCtlN;
    logic             mulHigh, mulHighN;
    logic             mulStart, mulBusy, mulDone;
    logic [2*W-1:0]   mulProd;
    logic [W-1:0]     mulRes;
    logic [SH_W-1:0]  shamt;
    logic [W:0]       sum;
    logic             accept;

    assign accept = in_valid && !stall && !flush;
    assign shamt  = readData1[SH_W-1:0];
    assign mulRes = mulHigh ? mulProd[2*W-1:W] : mulProd[W-1:0];

    always_comb begin
        inCtl.readMem  = ReadMem;
        inCtl.writeMem = WriteMem;
        inCtl.dataIn   = DataIn;
        inCtl.quarter  = quarter;
        inCtl.write    = write;
    end

    // Combinational ALU; carry/ovf only meaningful for ADD/SUB, NOP codes force all flags low
    always_comb begin
        aluOut = '0;
        sum    = '0;
        case (ALUOp)
            OP_ADD: begin
                sum           = {1'b0, readData0} + {1'b0, readData1};
                aluOut.result = sum[W-1:0];
                aluOut.carry  = sum[W];
                aluOut.ovf    = (readData0[W-1] == readData1[W-1]) && (sum[W-1] != readData0[W-1]);
            end
            OP_SUB: begin
                sum           = {1'b0, readData0} + {1'b0, ~readData1} + W1'(1);
                aluOut.result = sum[W-1:0];
                aluOut.carry  = sum[W];
                aluOut.ovf    = (readData0[W-1] != readData1[W-1]) && (sum[W-1] != readData0[W-1]);
            end
            OP_AND:   aluOut.result = readData0 & readData1;
            OP_OR:    aluOut.result = readData0 | readData1;
            OP_XOR:   aluOut.result = readData0 ^ readData1;
            OP_NOT:   aluOut.result = ~readData0;
            OP_SLL:   aluOut.result = readData0 << shamt;
            OP_SRL:   aluOut.result = readData0 >> shamt;
            OP_SRA:   aluOut.result = W'($signed(readData0) >>> shamt);
            OP_SLT:   aluOut.result = W'($signed(readData0) < $signed(readData1));
            OP_PASSB: aluOut.result = readData1;
            default:  aluOut.result = '0;
        endcase
        if (ALUOp < OP_NOP) begin
            aluOut.zero = (aluOut.result == '0);
            aluOut.neg  = aluOut.result[W-1];
        end
    end

    ex_mul16 u_mul (
        .clk   (clk),
        .rst   (rst),
        .kill  (flush),
        .start (mulStart),
        .a     (readData0),
        .b     (readData1),
        .busy  (mulBusy),
        .done  (mulDone),
        .prod  (mulProd)
    );

    // Next-state and registered-output values
    always_comb begin
        stateN    = state;
        countN    = count;
        stallN    = stall;
        outValidN = 1'b0;
        outN      = outQ;
        ctlN      = ctlQ;
        mulCtlN   = mulCtl;
        mulHighN  = mulHigh;
        mulStart  = 1'b0;

        if (flush) begin
            stateN = IDLE;
            stallN = 1'b0;
        end else begin
            case (state)
                MBUSY: begin
                    if (count != '0) begin
                        countN = count - CNT_W'(1);
                    end else if (mulDone && !mulBusy) begin
                        stateN      = MDONE;
                        stallN      = 1'b0;
                        outValidN   = 1'b1;
                        outN.result = mulRes;
                        outN.zero   = (mulRes == '0);
                        outN.neg    = mulRes[W-1];
                        outN.carry  = 1'b0;
                        outN.ovf    = 1'b0;
                        ctlN        = mulCtl;
                    end
                end
                // IDLE and MDONE both accept; stall is already low in MDONE
                default: begin
                    stateN = IDLE;
                    if (accept) begin
                        if (isMulOp(ALUOp)) begin
                            stateN   = MBUSY;
                            stallN   = 1'b1;
                            countN   = CNT_W'(MUL_ITERS - 1);
                            mulStart = 1'b1;
                            mulCtlN  = inCtl;
                            mulHighN = (ALUOp == OP_MULH);
                        end else begin
                            outValidN = 1'b1;
                            outN      = aluOut;
                            ctlN      = inCtl;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            stall     <= 1'b0;
            out_valid <= 1'b0;
            outQ      <= '0;
            ctlQ      <= '0;
            mulCtl    <= '0;
            mulHigh   <= 1'b0;
        end else begin
            state     <= stateN;
            count     <= countN;
            stall     <= stallN;
            out_valid <= outValidN;
            outQ      <= outN;
            ctlQ      <= ctlN;
            mulCtl    <= mulCtlN;
            mulHigh   <= mulHighN;
        end
    end

    assign result     = outQ.result;
    assign zero       = outQ.zero;
    assign neg        = outQ.neg;
    assign carry      = outQ.carry;
    assign ovf        = outQ.ovf;
    assign o_ReadMem  = ctlQ.readMem;
    assign o_WriteMem = ctlQ.writeMem;
    assign o_DataIn   = ctlQ.dataIn;
    assign o_quarter  = ctlQ.quarter;
    assign o_write    = ctlQ.write;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed corner cases plus randomized ops against an arithmetic model.
module tb_ex_stage;

    localparam logic [3:0] T_ADD = 4'd0, T_SUB = 4'd1, T_XOR = 4'd4, T_MUL = 4'd9, T_MULH = 4'd10;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush;
    logic [15:0] readData0, readData1, DataIn;
    logic [3:0]  ALUOp;
    logic        ReadMem, WriteMem, write;
    logic [1:0]  quarter;
    logic        stall, out_valid, zero, neg, carry, ovf;
    logic [15:0] result, o_DataIn;
    logic        o_ReadMem, o_WriteMem, o_write;
    logic [1:0]  o_quarter;

    int tests = 0;
    int fails = 0;
    logic [20:0] expPass;

    logic [3:0]  dOp [ND] = '{4'd0, 4'd1, 4'd11, 4'd8, 4'd7, 4'd6, 4'd14, 4'd1, 4'd0, 4'd1};
    logic [15:0] dA  [ND] = '{16'h7FFF, 16'h0003, 16'h8000, 16'h8000, 16'h8000,
                              16'h0001, 16'h1234, 16'h0005, 16'hFFFF, 16'h8000};
    logic [15:0] dB  [ND] = '{16'h0001, 16'h0005, 16'h0001, 16'h000F, 16'h000F,
                              16'h0000, 16'h5678, 16'h0005, 16'h0001, 16'h0001};
    logic [15:0] dR  [ND] = '{16'h8000, 16'hFFFE, 16'h0001, 16'hFFFF, 16'h0001,
                              16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF};
    // {zero, neg, carry, ovf}
    logic [3:0]  dF  [ND] = '{4'b0101, 4'b0100, 4'b0000, 4'b0100, 4'b0000,
                              4'b0000, 4'b0000, 4'b1010, 4'b1010, 4'b0011};

    ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .readData0(readData0), .readData1(readData1),
        .ALUOp(ALUOp), .ReadMem(ReadMem), .WriteMem(WriteMem), .DataIn(DataIn), .quarter(quarter),
        .write(write), .flush(flush), .stall(stall), .out_valid(out_valid), .result(result),
        .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .o_ReadMem(o_ReadMem),
        .o_WriteMem(o_WriteMem), .o_DataIn(o_DataIn), .o_quarter(o_quarter), .o_write(o_write)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    // Reference behaviour from plain integer arithmetic
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic [3:0] f);
        int ua, ub, sa, sb, sh, full;
        longint p;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        sh = int'(b[3:0]);
        r = 16'h0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin full = ua + ub; r = full[15:0]; c = (full > 65535);
                        full = sa + sb; v = (full > 32767) || (full < -32768); end
            4'd1: begin full = ua - ub; r = full[15:0]; c = (ua >= ub);
                        full = sa - sb; v = (full > 32767) || (full < -32768); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin p = longint'(ua) * longint'(2 ** sh); r = p[15:0]; end
            4'd7: begin full = ua / (2 ** sh); r = full[15:0]; end
            4'd8: begin
                full = (sa >= 0) ? sa / (2 ** sh) : -(((-sa) - 1) / (2 ** sh)) - 1;
                r = full[15:0];
            end
            4'd9:  begin p = longint'(ua) * longint'(ub); r = p[15:0]; end
            4'd10: begin p = longint'(ua) * longint'(ub); r = p[31:16]; end
            4'd11: r = (sa < sb) ? 16'h0001 : 16'h0000;
            4'd12: r = b;
            default: r = 16'h0;
        endcase
        f = {(op < 4'd13) && (r == 16'h0), (op < 4'd13) && r[15], c, v};
    endtask

    task automatic present(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1; ALUOp = op; readData0 = a; readData1 = b;
        ReadMem = 1'($urandom); WriteMem = 1'($urandom); DataIn = 16'($urandom);
        quarter = 2'($urandom); write = 1'($urandom);
        expPass = {ReadMem, WriteMem, DataIn, quarter, write};
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; ALUOp = 4'($urandom); readData0 = 16'($urandom); readData1 = 16'($urandom);
        ReadMem = 1'($urandom); WriteMem = 1'($urandom); DataIn = 16'($urandom);
        quarter = 2'($urandom); write = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({stall, out_valid, result, zero, neg, carry, ovf, o_ReadMem, o_WriteMem, o_DataIn, o_quarter, o_write} !== '0) begin
            fails++; $display("FAIL reset_outputs: got stall=%b ov=%b res=%h o_DataIn=%h want all zero",
                              stall, out_valid, result, o_DataIn);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [20:0] ep;
        for (int i = 0; i < ND; i++) begin
            present(dOp[i], dA[i], dB[i]); ep = expPass;
            @(posedge clk); #1;
            tests++;
            if ({out_valid, result} !== {1'b1, dR[i]}) begin
                fails++; $display("FAIL directed%0d_result: got ov=%b %h want ov=1 %h", i, out_valid, result, dR[i]);
            end
            tests++;
            if ({zero, neg, carry, ovf} !== dF[i]) begin
                fails++; $display("FAIL directed%0d_flags: got %b want %b", i, {zero, neg, carry, ovf}, dF[i]);
            end
            tests++;
            if ({o_ReadMem, o_WriteMem, o_DataIn, o_quarter, o_write} !== ep) begin
                fails++; $display("FAIL directed%0d_pass: got %h want %h", i,
                                  {o_ReadMem, o_WriteMem, o_DataIn, o_quarter, o_write}, ep);
            end
        end
        idle_inputs();
        @(posedge clk); #1;
        tests++;
        if ({out_valid, result} !== {1'b0, dR[ND-1]}) begin
            fails++; $display("FAIL directed_hold: got ov=%b %h want ov=0 %h", out_valid, result, dR[ND-1]);
        end
    endtask

    task automatic test_random_alu();
        logic [3:0]  op, ef;
        logic [15:0] a, b, er, lastRes;
        logic [20:0] ep, lastPass;
        bit valid;
        lastRes = '0; lastPass = '0;
        for (int i = 0; i < 80; i++) begin
            valid = (i == 0) || ($urandom_range(0, 3) != 0);
            do op = 4'($urandom); while (op == T_MUL || op == T_MULH);
            a = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 16'h7FFF : 16'($urandom);
            if (valid) begin present(op, a, b); ep = expPass; end
            else idle_inputs();
            @(posedge clk); #1;
            if (valid) begin
                model(op, a, b, er, ef);
                lastRes = er; lastPass = ep;
                tests++;
                if ({out_valid, result, zero, neg, carry, ovf} !== {1'b1, er, ef}) begin
                    fails++; $display("FAIL rand%0d_op%0d a=%h b=%h: got ov=%b res=%h f=%b want ov=1 res=%h f=%b",
                                      i, op, a, b, out_valid, result, {zero, neg, carry, ovf}, er, ef);
                end
                tests++;
                if ({o_ReadMem, o_WriteMem, o_DataIn, o_quarter, o_write} !== ep) begin
                    fails++; $display("FAIL rand%0d_pass: got %h want %h", i,
                                      {o_ReadMem, o_WriteMem, o_DataIn, o_quarter, o_write}, ep);
                end
            end else begin
                tests++;
                if ({out_valid, result, o_ReadMem, o_WriteMem, o_DataIn, o_quarter, o_write} !== {1'b0, lastRes, lastPass}) begin
                    fails++; $display("FAIL rand%0d_hold: got ov=%b res=%h want ov=0 res=%h", i, out_valid, result, lastRes);
                end
            end
        end
        idle_inputs();
    endtask

    // Accept one MUL/MULH, keep junk on the inputs while stalled, check timing and result
    task automatic run_mul(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] er, input string tag);
        logic [20:0] ep;
        int k, busyCyc;
        bit got;
        present(op, a, b); ep = expPass;
        @(posedge clk); #1;
        present(4'($urandom), 16'($urandom), 16'($urandom));
        tests++;
        if ({stall, out_valid} !== 2'b10) begin
            fails++; $display("FAIL %s_accept: got stall=%b ov=%b want stall=1 ov=0", tag, stall, out_valid);
        end
        busyCyc = 1; k = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk); #1; k++;
            if (out_valid) got = 1'b1;
            else if (stall) busyCyc++;
        end
        tests++;
        if (!got) begin fails++; $display("FAIL %s_timeout: got no out_valid in %0d cycles want 17", tag, k); end
        tests++;
        if (k != 17) begin fails++; $display("FAIL %s_latency: got %0d want 17", tag, k); end
        tests++;
        if (busyCyc != 17) begin fails++; $display("FAIL %s_stall_cycles: got %0d want 17", tag, busyCyc); end
        tests++;
        if (stall !== 1'b0) begin fails++; $display("FAIL %s_stall_at_done: got %b want 0", tag, stall); end
        tests++;
        if ({result, zero, neg, carry, ovf} !== {er, er == 16'h0, er[15], 2'b00}) begin
            fails++; $display("FAIL %s_result: got %h f=%b want %h f=%b", tag, result,
                              {zero, neg, carry, ovf}, er, {er == 16'h0, er[15], 2'b00});
        end
        tests++;
        if ({o_ReadMem, o_WriteMem, o_DataIn, o_quarter, o_write} !== ep) begin
            fails++; $display("FAIL %s_pass: got %h want %h", tag,
                              {o_ReadMem, o_WriteMem, o_DataIn, o_quarter, o_write}, ep);
        end
    endtask

    task automatic test_mul();
        logic [3:0]  op, ef;
        logic [15:0] a, b, er;
        run_mul(T_MUL, 16'h0123, 16'h0010, 16'h1230, "mul_spec");
        idle_inputs();
        @(posedge clk); #1;
        tests++;
        if ({out_valid, result} !== {1'b0, 16'h1230}) begin
            fails++; $display("FAIL mul_one_cycle: got ov=%b %h want ov=0 1230", out_valid, result);
        end
        for (int i = 0; i < 3; i++) begin
            op = 4'($urandom_range(9, 10)); a = 16'($urandom); b = 16'($urandom);
            model(op, a, b, er, ef);
            run_mul(op, a, b, er, "mul_rand");
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ef;
        logic [15:0] a, b, er;
        logic [20:0] ep;
        run_mul(T_MUL, 16'h0123, 16'h0010, 16'h1230, "b2b_mul");
        run_mul(T_MULH, 16'hFFFF, 16'hFFFF, 16'hFFFE, "b2b_mulh");
        a = 16'($urandom); b = 16'($urandom);
        present(T_ADD, a, b); ep = expPass;
        model(T_ADD, a, b, er, ef);
        @(posedge clk); #1;
        idle_inputs();
        tests++;
        if ({out_valid, result, zero, neg, carry, ovf} !== {1'b1, er, ef}) begin
            fails++; $display("FAIL b2b_add: got ov=%b %h f=%b want ov=1 %h f=%b",
                              out_valid, result, {zero, neg, carry, ovf}, er, ef);
        end
        tests++;
        if ({o_ReadMem, o_WriteMem, o_DataIn, o_quarter, o_write} !== ep) begin
            fails++; $display("FAIL b2b_add_pass: got %h want %h",
                              {o_ReadMem, o_WriteMem, o_DataIn, o_quarter, o_write}, ep);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drop: got ov=%b want 0", out_valid); end
    endtask

    task automatic test_flush();
        logic [20:0] ep;
        int seen;
        present(T_MUL, 16'h1111, 16'h0003);
        @(posedge clk); #1;
        idle_inputs();
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1; present(T_ADD, 16'h0001, 16'h0002);
        @(posedge clk); #1;
        flush = 1'b0; idle_inputs();
        tests++;
        if ({stall, out_valid} !== 2'b00) begin
            fails++; $display("FAIL flush_mul: got stall=%b ov=%b want 0 0", stall, out_valid);
        end
        seen = 0;
        repeat (25) begin @(posedge clk); #1; if (out_valid) seen++; end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
        flush = 1'b1; present(T_ADD, 16'h0010, 16'h0020);
        @(posedge clk); #1;
        flush = 1'b0; idle_inputs();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_single: got ov=%b want 0", out_valid); end
        present(T_ADD, 16'h0010, 16'h0020); ep = expPass;
        @(posedge clk); #1;
        idle_inputs();
        tests++;
        if ({out_valid, result, o_ReadMem, o_WriteMem, o_DataIn, o_quarter, o_write} !== {1'b1, 16'h0030, ep}) begin
            fails++; $display("FAIL flush_then_add: got ov=%b %h want ov=1 0030", out_valid, result);
        end
    endtask

    task automatic test_async_reset();
        int seen;
        present(T_XOR, 16'hA5A5, 16'h0F0F);
        @(posedge clk); #1;
        tests++;
        if (result !== 16'hAAAA) begin fails++; $display("FAIL areset_pre_xor: got %h want aaaa", result); end
        present(T_MUL, 16'h00FF, 16'h0101);
        @(posedge clk); #1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #4;
        tests++;
        if (stall !== 1'b1) begin fails++; $display("FAIL areset_pre_stall: got %b want 1", stall); end
        rst = 1'b1;
        #1;
        tests++;
        if ({stall, out_valid, result, zero, neg, carry, ovf, o_ReadMem, o_WriteMem, o_DataIn, o_quarter, o_write} !== '0) begin
            fails++; $display("FAIL areset_outputs: got stall=%b ov=%b res=%h o_DataIn=%h want all zero",
                              stall, out_valid, result, o_DataIn);
        end
        #2;
        rst = 1'b0;
        seen = 0;
        repeat (25) begin @(posedge clk); #1; if (out_valid) seen++; end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL areset_no_result: got %0d valid cycles want 0", seen); end
        present(T_ADD, 16'h0001, 16'h0001);
        @(posedge clk); #1;
        idle_inputs();
        tests++;
        if ({out_valid, result, zero, neg, carry, ovf} !== {1'b1, 16'h0002, 4'b0000}) begin
            fails++; $display("FAIL areset_add: got ov=%b %h f=%b want ov=1 0002 f=0000",
                              out_valid, result, {zero, neg, carry, ovf});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_alu();
        test_mul();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
